// File: rtl/mux_sel_pkg.sv
// mux_sel_pkg
//   Shared definitions for the mux-flop scheduler and its round-robin picker.
//   N_CH / SEL_W : channel count of the shared mux-flop and width of its select
//   sched_state_t: scheduler FSM states
//   onehot4      : channel index -> one-hot grant vector
package mux_sel_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        OUTPUT  = 2'd3
    } sched_state_t;

    function automatic logic [N_CH-1:0] onehot4(input logic [SEL_W-1:0] idx);
        logic [N_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4
//   Combinational round-robin picker over four requesters. The search starts
//   at ptr and walks ptr, ptr+1, ... modulo 4; the first set request wins.
//   req   : level requests, one bit per channel
//   ptr   : highest-priority channel this round
//   found : at least one request is pending
//   idx   : winning channel (only meaningful when found=1)
module rr_pick4
    import mux_sel_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    // Rotate req so that bit 0 of rot is the channel at ptr; then a fixed
    // lowest-index priority search on rot is a round-robin search on req.
    logic [2*N_CH-1:0] dbl;
    logic [N_CH-1:0]   rot;
    logic [SEL_W-1:0]  off;

    assign dbl = {req, req};
    assign rot = dbl[ptr +: N_CH];

    always_comb begin
        off = '0;
        for (int i = N_CH-1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
    end

    assign found = |rot;
    // 2-bit add wraps naturally, undoing the rotation.
    assign idx   = ptr + off;

endmodule

// File: rtl/mux_sel_sched.sv
// mux_sel_sched
//   Round-robin scheduler sharing one registered 4:1 mux-flop among four
//   requesters. Picks a channel, drives sel, waits dwell settle cycles plus
//   the flop's one-cycle latency, captures in_q and offers it on a
//   valid/ready port tagged with its channel.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req               : level requests per channel
//   dwell             : extra settle cycles, sampled at grant
//   sel               : registered select to the mux-flop (holds in IDLE)
//   in_q              : mux-flop q fed back
//   gnt               : registered one-hot grant, zero when idle
//   done              : one-cycle pulse on the served channel at handshake
//   out_valid/ready   : output handshake
//   out_bit, out_ch   : captured sample and its channel
//   busy              : any state other than IDLE
module mux_sel_sched
    import mux_sel_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CH-1:0]    req,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    input  logic               in_q,
    output logic [N_CH-1:0]    gnt,
    output logic [N_CH-1:0]    done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_bit,
    output logic [SEL_W-1:0]   out_ch,
    output logic               busy
);

    sched_state_t       state, state_d;
    logic [SEL_W-1:0]   ptr, ptr_d;
    logic [DWELL_W-1:0] cnt, cnt_d;
    logic [SEL_W-1:0]   sel_d, ch_d;
    logic [N_CH-1:0]    gnt_d;
    logic               vld_d, bit_d, busy_d;

    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic               hs;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign hs   = out_valid & out_ready;
    // gnt equals onehot(out_ch) while a sample is offered, so masking by gnt
    // gives the served channel's pulse directly.
    assign done = hs ? gnt : '0;

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        cnt_d   = cnt;
        sel_d   = sel;
        ch_d    = out_ch;
        gnt_d   = gnt;
        vld_d   = out_valid;
        bit_d   = out_bit;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    ch_d    = pick_idx;
                    gnt_d   = onehot4(pick_idx);
                    cnt_d   = dwell;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) state_d = CAPTURE;
                else           cnt_d   = cnt - 1'b1;
            end
            CAPTURE: begin
                // sel was registered at grant, so the flop has had at least
                // one edge on the new channel by now.
                bit_d   = in_q;
                vld_d   = 1'b1;
                state_d = OUTPUT;
            end
            OUTPUT: begin
                if (hs) begin
                    vld_d   = 1'b0;
                    gnt_d   = '0;
                    ptr_d   = out_ch + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            sel       <= '0;
            out_ch    <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
            sel       <= sel_d;
            out_ch    <= ch_d;
            gnt       <= gnt_d;
            out_valid <= vld_d;
            out_bit   <= bit_d;
            busy      <= busy_d;
        end
    end

endmodule
